input_conditioner: RTL and testbench

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/input_conditioner.sv | 111 +++++++++++
 tb/tb_input_conditioner.sv | 131 +++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// input_conditioner: synchronizes and (optionally) debounces eight asynchronous
// input pins, and produces one-cycle rising-edge flags for pins 0..6.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   reset        asynchronous, active-high reset; clears all state
//   din_raw[7:0] asynchronous external input pins
//   din[7:0]     synchronized (and debounced) input levels
//   flag_inputs  one-cycle pulse on each accepted 0->1 change of din[6:0];
//                bit 7 is always 0
//
// Parameter:
//   DEBOUNCE_CYCLES  consecutive stable synchronized cycles needed before a
//                    change is accepted (1..65535); used only with debounce.
//
// Configuration macro:
//   INPUT_DEBOUNCE_EN  when defined, per-bit debounce counters are built in.
//                      When undefined, din follows the synchronizer output
//                      one cycle later and every synchronized glitch passes.

module input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] din_raw,
    output logic [7:0] din,
    output logic [7:0] flag_inputs
);

    // Elaboration-time range guard for the debounce length.
    if (DEBOUNCE_CYCLES == 0 || DEBOUNCE_CYCLES > 65535) begin : g_param_check
        $error("input_conditioner: DEBOUNCE_CYCLES must be in 1..65535");
    end

    logic [7:0] s1_q;
    logic [7:0] s2_q;
    logic [7:0] din_q;
    logic [7:0] din_d;
    logic [7:0] flag_q;
    logic [7:0] flag_d;

    // Two-flop synchronizer; nothing downstream ever sees din_raw directly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= din_raw;
            s2_q <= s1_q;
        end
    end

`ifdef INPUT_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [7:0][CNT_W-1:0] cnt_q;
    logic [7:0][CNT_W-1:0] cnt_d;

    // A bit's counter runs only while s2 disagrees with the accepted level.
    // Reaching CNT_LAST on a further mismatch accepts the new level, so the
    // counter never exceeds DEBOUNCE_CYCLES-1 and cannot wrap.
    always_comb begin
        din_d = din_q;
        cnt_d = cnt_q;
        for (int i = 0; i < 8; i++) begin
            if (s2_q[i] == din_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                din_d[i] = s2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    always_comb begin
        din_d = s2_q;
    end
`endif

    // Flag is computed from the next din so it is high in the same cycle the
    // new 1 first appears on din. Bit 7 never flags.
    always_comb begin
        flag_d = din_d & ~din_q & 8'h7F;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            din_q  <= '0;
            flag_q <= '0;
        end else begin
            din_q  <= din_d;
            flag_q <= flag_d;
        end
    end

    assign din         = din_q;
    assign flag_inputs = flag_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES = 4. Expected
// din/flag values for each clock edge are queued as stimulus is applied and
// compared after the edge. Expectations follow the build: latency 2+4 with
// INPUT_DEBOUNCE_EN, latency 3 and glitch pass-through without it.

module tb_input_conditioner;

    localparam int unsigned DB = 4;
`ifdef INPUT_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
    localparam int LAT = 2 + DB;
`else
    localparam bit DEB = 1'b0;
    localparam int LAT = 3;
`endif

    logic       clk;
    logic       reset;
    logic [7:0] din_raw;
    logic [7:0] din;
    logic [7:0] flag_inputs;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        logic [7:0] din;
        logic [7:0] flag;
    } exp_t;

    exp_t sb[$];

    input_conditioner #(
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .din_raw    (din_raw),
        .din        (din),
        .flag_inputs(flag_inputs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Drive din_raw for the coming edge, queue what that edge must produce,
    // then compare 1 time unit after the edge.
    task automatic step(input logic [7:0] raw, input logic [7:0] e_din,
                        input logic [7:0] e_flag, input string tag, input int k);
        exp_t e;
        din_raw = raw;
        e.tag   = $sformatf("%s[%0d]", tag, k);
        e.din   = e_din;
        e.flag  = e_flag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, " din"}, din, e.din);
        chk({e.tag, " flag"}, flag_inputs, e.flag);
    endtask

    initial begin
        reset   = 1'b1;
        din_raw = 8'hFF;

        // Held in reset with all pins high: everything stays cleared.
        for (int k = 1; k <= 3; k++) step(8'hFF, 8'h00, 8'h00, "reset_hold", k);
        step(8'h00, 8'h00, 8'h00, "reset_hold", 4);
        reset = 1'b0;
        for (int k = 1; k <= 2; k++) step(8'h00, 8'h00, 8'h00, "idle", k);

        // Two bits rise together: din and flag appear at edge LAT.
        for (int k = 1; k <= LAT + 3; k++)
            step(8'h05, (k >= LAT) ? 8'h05 : 8'h00, (k == LAT) ? 8'h05 : 8'h00, "rise05", k);

        // Bit 3 high for 3 cycles: rejected by debounce, passed through without.
        for (int k = 1; k <= 10; k++)
            step((k <= 3) ? 8'h0D : 8'h05,
                 (!DEB && k >= 3 && k <= 5) ? 8'h0D : 8'h05,
                 (!DEB && k == 3) ? 8'h08 : 8'h00, "glitch3", k);

        // Falling edges never flag.
        for (int k = 1; k <= LAT + 2; k++)
            step(8'h00, (k >= LAT) ? 8'h00 : 8'h05, 8'h00, "fall05", k);

        // Bit 7 is conditioned but never flags, on rise or fall.
        for (int k = 1; k <= LAT + 2; k++)
            step(8'h80, (k >= LAT) ? 8'h80 : 8'h00, 8'h00, "rise80", k);
        for (int k = 1; k <= LAT + 2; k++)
            step(8'h00, (k >= LAT) ? 8'h00 : 8'h80, 8'h00, "fall80", k);

        // All pins rise at once: bits 0..6 flag together.
        for (int k = 1; k <= LAT + 2; k++)
            step(8'hFF, (k >= LAT) ? 8'hFF : 8'h00, (k == LAT) ? 8'h7F : 8'h00, "riseFF", k);
        for (int k = 1; k <= LAT + 2; k++)
            step(8'h00, (k >= LAT) ? 8'h00 : 8'hFF, 8'h00, "fallFF", k);

        // Reset in the middle of a bit-0 count, pin held high throughout.
        for (int k = 1; k <= 4; k++)
            step(8'h01, (k >= LAT) ? 8'h01 : 8'h00, (k == LAT) ? 8'h01 : 8'h00, "precnt", k);
        #3;
        reset = 1'b1;
        #1;
        chk("async_reset din", din, 8'h00);
        chk("async_reset flag", flag_inputs, 8'h00);
        step(8'h01, 8'h00, 8'h00, "in_reset", 1);
        reset = 1'b0;
        for (int k = 1; k <= LAT + 3; k++)
            step(8'h01, (k >= LAT) ? 8'h01 : 8'h00, (k == LAT) ? 8'h01 : 8'h00, "post_rst", k);

        // One-cycle high on bit 2: visible for one cycle only without debounce.
        for (int k = 1; k <= 6; k++)
            step((k == 1) ? 8'h05 : 8'h01,
                 (!DEB && k == 3) ? 8'h05 : 8'h01,
                 (!DEB && k == 3) ? 8'h04 : 8'h00, "pulse2", k);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
